// File: rtl/scnn_output_cordn_pipe.sv
// scnn_output_cordn_pipe: rebuilds dense weight/input positions from zero-run indices and emits
// the masked F*I output-coordinate product over a two-stage valid/ready pipeline.
module scnn_output_cordn_pipe #(
  parameter int F = 4,
  parameter int I = 4,
  parameter int KW = 3,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int WT_IW = 4,
  parameter int IP_IW = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [F*WT_IW-1:0]         in_wt_comp,
  input  logic [I*IP_IW-1:0]         in_ip_comp,
  input  logic [$clog2(F+1)-1:0]     in_wt_cnt,
  input  logic [$clog2(I+1)-1:0]     in_ip_cnt,
  input  logic                       in_wt_first,
  input  logic                       in_ip_first,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [F*I*IP_IW-1:0]       out_cords,
  output logic [F*I-1:0]             out_mask,
  output logic [WT_IW-1:0]           out_last_wt,
  output logic [IP_IW-1:0]           out_last_ip,
  output logic                       err_idx
);
  localparam int WCW = $clog2(F+1);
  localparam int ICW = $clog2(I+1);
  localparam int WPW = WT_IW + 1;
  localparam int IPW = IP_IW + 1;
  localparam int OW = IP_IW + 2;
  localparam int H = KW / 2;
  logic s1_vld, s2_adv, acc, bad;
  logic wv, iv, wok, iok, rok, cok;
  logic [WCW-1:0] wcnt, s1_wcnt;
  logic [ICW-1:0] icnt, s1_icnt;
  logic [WPW-1:0] wt_off, wrun, wlast, s1_wlast;
  logic [IPW-1:0] ip_off, irun, ilast, s1_ilast;
  logic [WPW-1:0] wpos [F];
  logic [WPW-1:0] s1_wpos [F];
  logic [IPW-1:0] ipos [I];
  logic [IPW-1:0] s1_ipos [I];
  logic [OW-1:0] orow, ocol;
  logic [F*I*IP_IW-1:0] cords;
  logic [F*I-1:0] mask;
  assign s2_adv = s1_vld & (!out_vld | out_rdy);
  assign in_rdy = !s1_vld | s2_adv;
  assign acc = in_vld & in_rdy;
  // Stage 1: dense positions from running offsets; a zero count still means lane 0 is valid
  always_comb begin
    wcnt = (in_wt_cnt == '0) ? WCW'(1) : (in_wt_cnt > WCW'(F)) ? WCW'(F) : in_wt_cnt;
    icnt = (in_ip_cnt == '0) ? ICW'(1) : (in_ip_cnt > ICW'(I)) ? ICW'(I) : in_ip_cnt;
    wrun = in_wt_first ? '0 : wt_off;
    irun = in_ip_first ? '0 : ip_off;
    for (int k = 0; k < F; k++) begin
      wpos[k] = wrun + WPW'(in_wt_comp[k*WT_IW +: WT_IW]);
      wrun = wpos[k] + WPW'(1);
    end
    for (int k = 0; k < I; k++) begin
      ipos[k] = irun + IPW'(in_ip_comp[k*IP_IW +: IP_IW]);
      irun = ipos[k] + IPW'(1);
    end
    wlast = wpos[0];
    ilast = ipos[0];
    for (int k = 0; k < F; k++) wlast = (WCW'(k) == wcnt - WCW'(1)) ? wpos[k] : wlast;
    for (int k = 0; k < I; k++) ilast = (ICW'(k) == icnt - ICW'(1)) ? ipos[k] : ilast;
  end
  // Stage 2: shift each input position by the kernel tap offset; anything off-plane is forced to 0
  always_comb begin
    cords = '0;
    mask = '0;
    bad = 1'b0;
    wv = 1'b0;
    iv = 1'b0;
    wok = 1'b0;
    iok = 1'b0;
    rok = 1'b0;
    cok = 1'b0;
    orow = '0;
    ocol = '0;
    for (int f = 0; f < F; f++) begin
      for (int i = 0; i < I; i++) begin
        wv = f < int'(s1_wcnt);
        iv = i < int'(s1_icnt);
        wok = s1_wpos[f] < WPW'(KW*KW);
        iok = s1_ipos[i] < IPW'(IMG_W*IMG_H);
        orow = OW'(s1_ipos[i] / IPW'(IMG_W)) + OW'(H) - OW'(s1_wpos[f] / WPW'(KW));
        ocol = OW'(s1_ipos[i] % IPW'(IMG_W)) + OW'(H) - OW'(s1_wpos[f] % WPW'(KW));
        rok = !orow[OW-1] && orow < OW'(IMG_H);
        cok = !ocol[OW-1] && ocol < OW'(IMG_W);
        mask[f*I+i] = wv & iv & wok & iok & rok & cok;
        cords[(f*I+i)*IP_IW +: IP_IW] = mask[f*I+i] ? IP_IW'(orow * OW'(IMG_W) + ocol) : '0;
        bad = bad | (wv & !wok) | (iv & !iok);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      wt_off <= '0;
      ip_off <= '0;
      out_vld <= 1'b0;
      out_cords <= '0;
      out_mask <= '0;
      out_last_wt <= '0;
      out_last_ip <= '0;
      err_idx <= 1'b0;
    end else begin
      if (in_rdy) s1_vld <= in_vld;
      if (acc) begin
        s1_wpos <= wpos;
        s1_ipos <= ipos;
        s1_wcnt <= wcnt;
        s1_icnt <= icnt;
        s1_wlast <= wlast;
        s1_ilast <= ilast;
        wt_off <= wlast + WPW'(1);
        ip_off <= ilast + IPW'(1);
      end
      if (!out_vld | out_rdy) out_vld <= s1_vld;
      if (s2_adv) begin
        out_cords <= cords;
        out_mask <= mask;
        out_last_wt <= s1_wlast[WT_IW-1:0];
        out_last_ip <= s1_ilast[IP_IW-1:0];
        err_idx <= err_idx | bad;
      end
    end
  end
endmodule

// File: tb/tb_scnn_output_cordn_pipe.sv
// tb_scnn_output_cordn_pipe: directed beats with a scoreboard of coordinates computed from
// the dense-position and kernel-offset definitions, plus directed checks of key values.
module tb_scnn_output_cordn_pipe;
  logic clk = 1'b0;
  logic rst, in_vld, in_rdy, in_wt_first, in_ip_first, out_vld, out_rdy, err_idx;
  logic [15:0] in_wt_comp;
  logic [31:0] in_ip_comp;
  logic [2:0] in_wt_cnt, in_ip_cnt;
  logic [127:0] out_cords, hold;
  logic [15:0] out_mask;
  logic [3:0] out_last_wt;
  logic [7:0] out_last_ip;
  typedef struct packed {
    logic [127:0] cords;
    logic [15:0] mask;
    logic [3:0] lw;
    logic [7:0] li;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0, failures = 0, acc_cnt = 0, base_cnt;
  int m_woff = 0, m_ioff = 0, wn, inn, b, orow, ocol;
  int wp[4];
  int ipp[4];

  scnn_output_cordn_pipe dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_wt_comp(in_wt_comp), .in_ip_comp(in_ip_comp),
    .in_wt_cnt(in_wt_cnt), .in_ip_cnt(in_ip_cnt),
    .in_wt_first(in_wt_first), .in_ip_first(in_ip_first),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_cords(out_cords), .out_mask(out_mask),
    .out_last_wt(out_last_wt), .out_last_ip(out_last_ip), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_woff = 0;
      m_ioff = 0;
    end else begin
      if (in_vld && in_rdy) begin
        acc_cnt++;
        wn = (in_wt_cnt == 0) ? 1 : int'(in_wt_cnt);
        inn = (in_ip_cnt == 0) ? 1 : int'(in_ip_cnt);
        b = in_wt_first ? 0 : m_woff;
        for (int k = 0; k < 4; k++) begin
          wp[k] = b + int'(in_wt_comp[k*4 +: 4]);
          b = wp[k] + 1;
        end
        b = in_ip_first ? 0 : m_ioff;
        for (int k = 0; k < 4; k++) begin
          ipp[k] = b + int'(in_ip_comp[k*8 +: 8]);
          b = ipp[k] + 1;
        end
        m_woff = wp[wn-1] + 1;
        m_ioff = ipp[inn-1] + 1;
        e = '0;
        e.lw = 4'(wp[wn-1]);
        e.li = 8'(ipp[inn-1]);
        for (int f = 0; f < 4; f++)
          for (int i = 0; i < 4; i++)
            if (f < wn && i < inn && wp[f] < 9 && ipp[i] < 64) begin
              orow = ipp[i] / 8 - (wp[f] / 3 - 1);
              ocol = ipp[i] % 8 - (wp[f] % 3 - 1);
              if (orow >= 0 && orow < 8 && ocol >= 0 && ocol < 8) begin
                e.mask[f*4+i] = 1'b1;
                e.cords[(f*4+i)*8 +: 8] = 8'(orow * 8 + ocol);
              end
            end
        sb.push_back(e);
      end
      if (out_vld && out_rdy) begin
        checks++;
        assert (sb.size() > 0) else begin
          failures++;
          $error("FAIL sb_unexpected_out obs=out_vld exp=no_output");
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          assert (out_cords === e.cords) else begin
            failures++;
            $error("FAIL sb_cords obs=%h exp=%h", out_cords, e.cords);
          end
          checks++;
          assert (out_mask === e.mask) else begin
            failures++;
            $error("FAIL sb_mask obs=%h exp=%h", out_mask, e.mask);
          end
          checks++;
          assert ({out_last_wt, out_last_ip} === {e.lw, e.li}) else begin
            failures++;
            $error("FAIL sb_last obs=%0d/%0d exp=%0d/%0d", out_last_wt, out_last_ip, e.lw, e.li);
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] wc, input logic [31:0] ic, input logic [2:0] wn_i,
                      input logic [2:0] in_i, input logic wf, input logic ipf);
    @(posedge clk);
    #1;
    in_wt_comp = wc;
    in_ip_comp = ic;
    in_wt_cnt = wn_i;
    in_ip_cnt = in_i;
    in_wt_first = wf;
    in_ip_first = ipf;
    in_vld = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (in_rdy) break;
      if (t == 29) begin
        checks++;
        failures++;
        $error("FAIL send_timeout obs=in_rdy_low exp=accept");
      end
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic wait_out();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_vld) return;
    end
    checks++;
    failures++;
    $error("FAIL out_timeout obs=no_out_vld exp=out_vld");
  endtask

  initial begin
    rst = 1'b1;
    in_vld = 1'b0;
    out_rdy = 1'b1;
    in_wt_comp = '0;
    in_ip_comp = '0;
    in_wt_cnt = 3'd1;
    in_ip_cnt = 3'd1;
    in_wt_first = 1'b0;
    in_ip_first = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_vld", 128'(out_vld), 128'd0);
    chk("rst_in_rdy", 128'(in_rdy), 128'd1);
    chk("rst_cords", out_cords, 128'd0);
    chk("rst_mask_last_err", {out_mask, out_last_wt, out_last_ip, err_idx}, 128'd0);
    // centre-ish plane: wt 0..3 against ip 9..12
    send(16'h0000, 32'h00000009, 3'd4, 3'd4, 1'b1, 1'b1);
    wait_out();
    chk("t1_wt0_i0", 128'(out_cords[7:0]), 128'd18);
    chk("t1_wt0_i3", 128'(out_cords[31:24]), 128'd21);
    chk("t1_wt3_i0", 128'(out_cords[103:96]), 128'd10);
    chk("t1_wt3_i3", 128'(out_cords[127:120]), 128'd13);
    chk("t1_mask", 128'(out_mask), 128'hFFFF);
    // plane edges
    send(16'h0000, 32'h00000007, 3'd1, 3'd1, 1'b1, 1'b1);
    wait_out();
    chk("t2_col8_mask", 128'(out_mask), 128'd0);
    chk("t2_col8_cords", out_cords, 128'd0);
    send(16'h0008, 32'h00000000, 3'd1, 3'd1, 1'b1, 1'b1);
    wait_out();
    chk("t2_rowm1_mask", 128'(out_mask), 128'd0);
    chk("t2_rowm1_cords", out_cords, 128'd0);
    // input offset carried across beats
    send(16'h0000, 32'h00000000, 3'd4, 3'd4, 1'b1, 1'b1);
    wait_out();
    send(16'h0000, 32'h00000001, 3'd4, 3'd4, 1'b1, 1'b0);
    wait_out();
    chk("t3_last_ip", 128'(out_last_ip), 128'd8);
    // backpressure
    @(posedge clk);
    #1 out_rdy = 1'b0;
    base_cnt = acc_cnt;
    send(16'h0000, 32'h00000000, 3'd4, 3'd4, 1'b1, 1'b1);
    send(16'h0001, 32'h00000102, 3'd4, 3'd4, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    in_wt_comp = 16'h0010;
    in_ip_comp = 32'h00000003;
    in_wt_cnt = 3'd2;
    in_ip_cnt = 3'd3;
    in_wt_first = 1'b1;
    in_ip_first = 1'b0;
    in_vld = 1'b1;
    @(negedge clk);
    hold = out_cords;
    chk("t4_in_rdy_low", 128'(in_rdy), 128'd0);
    chk("t4_accepted", 128'(acc_cnt - base_cnt), 128'd2);
    @(negedge clk);
    chk("t4_out_vld_held", 128'(out_vld), 128'd1);
    chk("t4_cords_stable", out_cords, hold);
    @(posedge clk);
    #1 out_rdy = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_rdy) break;
    end
    @(posedge clk);
    #1 in_vld = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_all_accepted", 128'(acc_cnt - base_cnt), 128'd3);
    chk("t4_drained", 128'(sb.size()), 128'd0);
    // partial lanes and out-of-range index
    send(16'h0000, 32'h00000009, 3'd4, 3'd2, 1'b1, 1'b1);
    wait_out();
    chk("t5_mask_hi_lanes", 128'(out_mask & 16'hCCCC), 128'd0);
    chk("t5_mask_lo_lanes", 128'(out_mask & 16'h3333), 128'h3333);
    chk("t5_err_clear", 128'(err_idx), 128'd0);
    send(16'h0009, 32'h00000000, 3'd1, 3'd1, 1'b1, 1'b1);
    wait_out();
    chk("t5_err_set", 128'(err_idx), 128'd1);
    chk("t5_bad_mask", 128'(out_mask), 128'd0);
    send(16'h0000, 32'h00000009, 3'd0, 3'd0, 1'b1, 1'b1);
    wait_out();
    chk("t5_err_sticky", 128'(err_idx), 128'd1);
    chk("t5_cnt0_mask", 128'(out_mask), 128'd1);
    // reset with beats in flight
    @(posedge clk);
    #1 out_rdy = 1'b0;
    send(16'h0000, 32'h00000005, 3'd4, 3'd4, 1'b1, 1'b1);
    send(16'h0000, 32'h00000005, 3'd4, 3'd4, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    chk("t6_out_vld", 128'(out_vld), 128'd0);
    chk("t6_err", 128'(err_idx), 128'd0);
    chk("t6_in_rdy", 128'(in_rdy), 128'd1);
    send(16'h0000, 32'h00000001, 3'd4, 3'd4, 1'b0, 1'b0);
    wait_out();
    chk("t6_last_ip", 128'(out_last_ip), 128'd4);
    chk("t6_last_wt", 128'(out_last_wt), 128'd3);
    repeat (3) @(negedge clk);
    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
